// File: rtl/spi_buf_master.sv
// Buffered SPI master (mode 0, MSB first): software fills a TX buffer, starts a burst with a
// control write, and reads back received bytes and status over a registered 16-bit bus.
module spi_buf_master #(
  parameter int ADDR_W        = 4,
  parameter int CLKS_PER_HALF = 2
) (
  input  logic              clk_in,
  input  logic              rst,
  input  logic              wr,
  input  logic              sel,
  input  logic [ADDR_W-1:0] addr,
  input  logic [7:0]        wdata,
  output logic [15:0]       rdata,
  output logic              o_busy,
  output logic              o_SPI_Clk,
  output logic              o_SPI_MOSI,
  input  logic              i_SPI_MISO
);
  localparam int DEPTH = 1 << ADDR_W;
  localparam int DIV_W = (CLKS_PER_HALF > 1) ? $clog2(CLKS_PER_HALF) : 1;
  localparam logic [DIV_W-1:0]  HALF_M1  = DIV_W'(CLKS_PER_HALF - 1);
  localparam logic [DIV_W-1:0]  DIV_ONE  = DIV_W'(1);
  localparam logic [ADDR_W-1:0] IDX_ONE  = ADDR_W'(1);
  localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W + 1)'(1);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_SHIFT, S_STORE, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d, n_last_q, n_last_d;
  logic [ADDR_W:0]   rx_cnt_q, rx_cnt_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic [2:0]        bit_cnt_q, bit_cnt_d;
  logic [7:0]        tx_sh_q, tx_sh_d, rx_sh_q, rx_sh_d;
  logic              sclk_q, sclk_d, mosi_q, mosi_d, busy_q, busy_d;
  logic [15:0]       rdata_q, rdata_d;
  logic              tx_we, rx_we;
  logic              unused_wdata;

  logic [7:0] tx_buf [DEPTH];
  logic [7:0] rx_buf [DEPTH];

  assign unused_wdata = ^wdata;

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    n_last_d  = n_last_q;
    rx_cnt_d  = rx_cnt_q;
    div_d     = div_q;
    bit_cnt_d = bit_cnt_q;
    tx_sh_d   = tx_sh_q;
    rx_sh_d   = rx_sh_q;
    sclk_d    = sclk_q;
    mosi_d    = mosi_q;
    busy_d    = busy_q;
    tx_we     = 1'b0;
    rx_we     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        // Writes are only honoured here; the busy phases ignore the bus entirely.
        if (wr && !busy_q) begin
          if (sel) begin
            tx_we = 1'b1;
          end else begin
            n_last_d = wdata[ADDR_W-1:0];
            if (wdata[7]) begin
              rx_cnt_d = '0;
              idx_d    = '0;
              busy_d   = 1'b1;
              state_d  = S_LOAD;
            end
          end
        end
      end
      S_LOAD: begin
        tx_sh_d   = tx_buf[idx_q];
        mosi_d    = tx_buf[idx_q][7];
        bit_cnt_d = 3'd7;
        div_d     = '0;
        sclk_d    = 1'b0;
        state_d   = S_SHIFT;
      end
      S_SHIFT: begin
        if (div_q == HALF_M1) begin
          div_d  = '0;
          sclk_d = !sclk_q;
          if (!sclk_q) begin
            rx_sh_d = {rx_sh_q[6:0], i_SPI_MISO};
          end else begin
            tx_sh_d   = {tx_sh_q[6:0], 1'b0};
            mosi_d    = tx_sh_q[6];
            bit_cnt_d = bit_cnt_q - 3'd1;
            if (bit_cnt_q == 3'd0) state_d = S_STORE;
          end
        end else begin
          div_d = div_q + DIV_ONE;
        end
      end
      S_STORE: begin
        rx_we    = 1'b1;
        rx_cnt_d = rx_cnt_q + CNT_ONE;
        if (idx_q == n_last_q) begin
          state_d = S_DONE;
        end else begin
          idx_d   = idx_q + IDX_ONE;
          state_d = S_LOAD;
        end
      end
      S_DONE: begin
        mosi_d  = 1'b0;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    rdata_d = sel ? {tx_buf[addr], rx_buf[addr]} : {busy_q, 7'b0, 8'(rx_cnt_q)};
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      state_q   <= S_IDLE;
      idx_q     <= '0;
      n_last_q  <= '0;
      rx_cnt_q  <= '0;
      div_q     <= '0;
      bit_cnt_q <= '0;
      tx_sh_q   <= '0;
      rx_sh_q   <= '0;
      sclk_q    <= 1'b0;
      mosi_q    <= 1'b0;
      busy_q    <= 1'b0;
      rdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      n_last_q  <= n_last_d;
      rx_cnt_q  <= rx_cnt_d;
      div_q     <= div_d;
      bit_cnt_q <= bit_cnt_d;
      tx_sh_q   <= tx_sh_d;
      rx_sh_q   <= rx_sh_d;
      sclk_q    <= sclk_d;
      mosi_q    <= mosi_d;
      busy_q    <= busy_d;
      rdata_q   <= rdata_d;
    end
  end

  // Buffers keep their contents across reset; reset only blocks writes in the same cycle.
  always_ff @(posedge clk_in) begin
    if (tx_we && !rst) tx_buf[addr] <= wdata;
    if (rx_we && !rst) rx_buf[idx_q] <= rx_sh_q;
  end

  assign rdata      = rdata_q;
  assign o_busy     = busy_q;
  assign o_SPI_Clk  = sclk_q;
  assign o_SPI_MOSI = mosi_q;
endmodule

// File: tb/tb_spi_buf_master.sv
// Bench for spi_buf_master: reset, loopback bursts, write-while-busy, mid-burst reset and
// an externally driven MISO pattern.
module tb_spi_buf_master;
  localparam int AW  = 4;
  localparam int CPH = 2;
  localparam int BYTE_CYC = 2 + 16 * CPH;

  logic        clk_in, rst, wr, sel;
  logic [AW-1:0] addr;
  logic [7:0]  wdata;
  logic [15:0] rdata;
  logic        o_busy, o_SPI_Clk, o_SPI_MOSI, i_SPI_MISO;
  logic        loop_en, miso_drv;

  int checks = 0;
  int errors = 0;
  logic [15:0] exp_q[$];

  typedef struct {
    logic          sel;
    logic [AW-1:0] addr;
    logic [15:0]   exp;
  } vec_t;
  vec_t vecs[17];

  assign i_SPI_MISO = loop_en ? o_SPI_MOSI : miso_drv;

  spi_buf_master #(.ADDR_W(AW), .CLKS_PER_HALF(CPH)) dut (
    .clk_in(clk_in), .rst(rst), .wr(wr), .sel(sel), .addr(addr), .wdata(wdata),
    .rdata(rdata), .o_busy(o_busy), .o_SPI_Clk(o_SPI_Clk), .o_SPI_MOSI(o_SPI_MOSI),
    .i_SPI_MISO(i_SPI_MISO)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wr_tx(input logic [AW-1:0] a, input logic [7:0] d);
    sel = 1'b1; addr = a; wdata = d; wr = 1'b1;
    tick();
    wr = 1'b0;
  endtask

  task automatic wr_ctl(input logic [7:0] d);
    sel = 1'b0; wdata = d; wr = 1'b1;
    tick();
    wr = 1'b0;
  endtask

  // Push the expectation when the read is driven, pop it when rdata appears.
  task automatic rd_expect(input string name, input logic s, input logic [AW-1:0] a,
                           input logic [15:0] e);
    logic [15:0] want;
    exp_q.push_back(e);
    sel = s; addr = a; wr = 1'b0;
    tick();
    want = exp_q.pop_front();
    chk(name, {16'h0, rdata}, {16'h0, want});
  endtask

  task automatic run_burst(input logic [7:0] ctl, input bit inject, input logic [7:0] miso_pat,
                           output int cyc, output int pulses, output int bad_hi,
                           output int bad_lo, output logic [7:0] mosi_pat,
                           output logic mosi_seen);
    int run;
    logic prev;
    wr_ctl(ctl);
    cyc = 0; pulses = 0; bad_hi = 0; bad_lo = 0; mosi_pat = '0; mosi_seen = 1'b0;
    run = 0; prev = 1'b0;
    while (o_busy === 1'b1 && cyc < 2000) begin
      if (o_SPI_Clk && !prev) begin
        if (pulses > 0 && run != CPH) bad_lo++;
        pulses++;
        mosi_pat = {mosi_pat[6:0], o_SPI_MOSI};
        run = 1;
      end else if (!o_SPI_Clk && prev) begin
        if (run != CPH) bad_hi++;
        run = 1;
      end else begin
        run++;
      end
      mosi_seen = mosi_seen | o_SPI_MOSI;
      if (!o_SPI_Clk) miso_drv = miso_pat[7 - (pulses % 8)];
      if (inject) begin
        if (cyc == 20) begin
          sel = 1'b1; addr = 1; wdata = 8'hFF; wr = 1'b1;
        end else if (cyc == 21) begin
          sel = 1'b0; wdata = 8'h80;
        end else if (cyc == 22) begin
          wr = 1'b0;
        end
      end
      prev = o_SPI_Clk;
      tick();
      cyc++;
    end
    wr = 1'b0;
  endtask

  initial begin
    int cyc, pulses, bad_hi, bad_lo;
    logic [7:0] mpat;
    logic mseen;

    for (int i = 0; i < 16; i++) begin
      vecs[i].sel  = 1'b1;
      vecs[i].addr = AW'(i);
      vecs[i].exp  = {8'(8'h10 + i), 8'(8'h10 + i)};
    end
    vecs[16].sel = 1'b0; vecs[16].addr = '0; vecs[16].exp = 16'h0010;

    rst = 1'b1; wr = 1'b0; sel = 1'b0; addr = '0; wdata = '0;
    loop_en = 1'b1; miso_drv = 1'b0;

    // Reset with write traffic toggling underneath.
    wr = 1'b1; sel = 1'b1; addr = 0; wdata = 8'h55;
    tick();
    sel = 1'b0; wdata = 8'h80;
    tick();
    chk("reset_rdata", {16'h0, rdata}, 32'h0);
    chk("reset_busy", {31'h0, o_busy}, 32'h0);
    chk("reset_sclk", {31'h0, o_SPI_Clk}, 32'h0);
    chk("reset_mosi", {31'h0, o_SPI_MOSI}, 32'h0);
    rst = 1'b0; wr = 1'b0;
    rd_expect("reset_ctl_read", 1'b0, 0, 16'h0000);

    // Single byte, loopback.
    wr_tx(0, 8'h0A);
    run_burst(8'h80, 1'b0, 8'h00, cyc, pulses, bad_hi, bad_lo, mpat, mseen);
    chk("single_busy_cycles", cyc, 1 * BYTE_CYC + 1);
    chk("single_pulses", pulses, 8);
    chk("single_high_width", bad_hi, 0);
    chk("single_low_width", bad_lo, 0);
    chk("single_mosi_pattern", {24'h0, mpat}, 32'h0A);
    rd_expect("single_buf0", 1'b1, 0, 16'h0A0A);
    rd_expect("single_ctl", 1'b0, 0, 16'h0001);

    // Full-buffer burst, table-driven readback.
    for (int i = 0; i < 16; i++) wr_tx(AW'(i), 8'(8'h10 + i));
    run_burst(8'h8F, 1'b0, 8'h00, cyc, pulses, bad_hi, bad_lo, mpat, mseen);
    chk("full_busy_cycles", cyc, 16 * BYTE_CYC + 1);
    chk("full_pulses", pulses, 128);
    chk("full_high_width", bad_hi, 0);
    for (int i = 0; i < 17; i++)
      rd_expect($sformatf("full_vec%0d", i), vecs[i].sel, vecs[i].addr, vecs[i].exp);

    // Writes during a two-byte burst are dropped.
    run_burst(8'h81, 1'b1, 8'h00, cyc, pulses, bad_hi, bad_lo, mpat, mseen);
    chk("busy_wr_cycles", cyc, 2 * BYTE_CYC + 1);
    chk("busy_wr_pulses", pulses, 16);
    rd_expect("busy_wr_buf1", 1'b1, 1, 16'h1111);
    rd_expect("busy_wr_ctl", 1'b0, 0, 16'h0002);
    chk("busy_wr_idle", {31'h0, o_busy}, 32'h0);

    // Reset lands in the 4th bit of byte 0.
    wr_tx(0, 8'h5A);
    wr_ctl(8'h80);
    repeat (14) tick();
    chk("midrst_busy_before", {31'h0, o_busy}, 32'h1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_busy", {31'h0, o_busy}, 32'h0);
    chk("midrst_sclk", {31'h0, o_SPI_Clk}, 32'h0);
    chk("midrst_mosi", {31'h0, o_SPI_MOSI}, 32'h0);
    rd_expect("midrst_ctl", 1'b0, 0, 16'h0000);
    rd_expect("midrst_buf0", 1'b1, 0, 16'h5A10);
    run_burst(8'h80, 1'b0, 8'h00, cyc, pulses, bad_hi, bad_lo, mpat, mseen);
    chk("midrst_rerun_cycles", cyc, BYTE_CYC + 1);
    rd_expect("midrst_rerun_buf0", 1'b1, 0, 16'h5A5A);
    rd_expect("midrst_rerun_ctl", 1'b0, 0, 16'h0001);

    // External MISO pattern with an all-zero TX byte.
    loop_en = 1'b0;
    wr_tx(0, 8'h00);
    run_burst(8'h80, 1'b0, 8'hC3, cyc, pulses, bad_hi, bad_lo, mpat, mseen);
    chk("ext_cycles", cyc, BYTE_CYC + 1);
    chk("ext_mosi_zero", {31'h0, mseen}, 32'h0);
    rd_expect("ext_buf0", 1'b1, 0, 16'h00C3);

    chk("scoreboard_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/spi_buf_master.md
Name: spi_buf_master

Overview:
- Buffered SPI master that sits directly downstream of the external register-write port (wr/sel/data bus) and drives the SPI pins.
- Software loads up to DEPTH bytes into a TX buffer, then writes a control word to start a burst.
- The block shifts every byte out in SPI mode 0, MSB first, and stores each simultaneously received MISO byte into an RX buffer.
- Results are read back over a 16-bit output bus.

Parameters:
ADDR_W, 4, buffer address width; DEPTH = 2**ADDR_W bytes; legal range 1..7
CLKS_PER_HALF, 2, clk_in cycles per SCLK half-period; minimum 1

Ports:
clk_in  in  1  system clock; all logic on rising edge
rst  in  1  synchronous, active-high reset
wr  in  1  write strobe, single-cycle
sel  in  1  0 = control register, 1 = TX buffer
addr  in  ADDR_W  buffer index for TX writes and readback
wdata  in  8  write data
rdata  out  16  registered readback
o_busy  out  1  burst in progress
o_SPI_Clk  out  1  SCLK, idle low
o_SPI_MOSI  out  1  serial data out
i_SPI_MISO  in  1  serial data in

Behaviour:
- Reset (rst=1 at a rising edge):
  - state=IDLE; o_busy=0, o_SPI_Clk=0, o_SPI_MOSI=0, rdata=0.
  - rx_cnt=0, idx=0, n_last=0.
  - Buffer contents are not cleared.
  - Reset mid-burst aborts immediately; no further RX writes occur.
- Control write (wr=1, sel=0, state IDLE):
  - n_last <= wdata[ADDR_W-1:0].
  - If wdata[7]=1: rx_cnt <= 0, idx <= 0, state <= LOAD, o_busy=1 from the next cycle.
  - If wdata[7]=0: only n_last is updated.
- TX write (wr=1, sel=1, state IDLE): tx_buf[addr] <= wdata.
- Any wr while o_busy=1 is ignored (both buffers and control unchanged).
- Readback (one-cycle latency, updated every cycle from sel/addr sampled at the edge):
  - sel=0: rdata = {o_busy, 7'b0, rx_cnt zero-extended to 8 bits}.
  - sel=1: rdata = {tx_buf[addr], rx_buf[addr]}.
- FSM:
  - IDLE: waits for a start write.
  - LOAD (1 cycle): shreg <= tx_buf[idx]; o_SPI_MOSI <= tx_buf[idx][7]; bit counter=7; divider=0.
  - SHIFT: each half-period is CLKS_PER_HALF cycles.
    - Rising SCLK edge: sample i_SPI_MISO into rx shift LSB.
    - Falling SCLK edge: shift shreg left and drive the next MSB on o_SPI_MOSI.
    - After the 8th falling edge (SCLK back low), go to STORE.
    - One byte occupies exactly 16*CLKS_PER_HALF cycles in SHIFT.
  - STORE (1 cycle): rx_buf[idx] <= received byte; rx_cnt <= rx_cnt+1.
    - If idx==n_last, go to DONE; else idx <= idx+1 and go to LOAD.
  - DONE (1 cycle): o_SPI_MOSI <= 0, o_busy <= 0, then IDLE.
- Burst length is n_last+1 bytes. n_last=0 sends one byte; n_last=DEPTH-1 sends the full buffer with no index wrap.
- Burst duration from the start-write edge until o_busy falls: (n_last+1)*(2+16*CLKS_PER_HALF)+1 cycles.
- o_SPI_Clk is low in IDLE, LOAD, STORE and DONE. There are no glitches or runt pulses.
- Simultaneous rst and wr: reset wins.
- A start write with wdata[7]=1 while busy is dropped. Software must poll o_busy.

Test Plan:
- Reset: hold rst=1 for 2 cycles with wr toggling -> rdata=0, o_busy=0, o_SPI_Clk=0, o_SPI_MOSI=0; a subsequent control read returns 16'h0000.
- Single byte, loopback (o_SPI_MOSI tied to i_SPI_MISO), CLKS_PER_HALF=2:
  - Stimulus: write tx_buf[0]=8'h0A, then control 8'h80.
  - o_busy high for exactly 35 cycles; exactly 8 SCLK pulses, each 2 cycles high and 2 low.
  - MOSI pattern 0,0,0,0,1,0,1,0.
  - Reading sel=1 addr=0 returns 16'h0A0A; control read returns 16'h0001.
- Multi-byte with wrap boundary, loopback:
  - Stimulus: tx_buf[0..15] = 8'h10+i, then control 8'h8F.
  - All 16 RX entries equal their TX values; rx_cnt=16 (control read 16'h0010); idx never exceeds 15.
- Write-while-busy:
  - Mid-burst, write tx_buf[1]=8'hFF and control 8'h80.
  - Neither takes effect; burst completes normally with the original data.
  - After o_busy falls, tx_buf[1] still holds its old value.
- Reset mid-operation:
  - Assert rst during the 4th bit of byte 0.
  - Next cycle: o_busy=0, o_SPI_Clk=0, rx_cnt=0.
  - rx_buf[0] is not written; a new burst afterwards works.
- External MISO pattern: drive i_SPI_MISO = 8'hC3 MSB-first, sampled on rising SCLK, with tx 8'h00 -> rx_buf[0]=8'hC3 and MOSI held 0 throughout.
